// File: rtl/linear_proj_pkg.sv
// Shared sizing helpers and serializer state type for the matmul output path.
package linear_proj_pkg;

    localparam int ROW_SIZE_MAT_C = 2;
    localparam int COL_SIZE_MAT_C = 4;

    function automatic int calc_slice_w(input int width_out, input int chunk_size,
                                        input int cores_a, input int cores_b,
                                        input int modules);
        return width_out * chunk_size * cores_a * cores_b * modules;
    endfunction

    function automatic int calc_num_blocks(input int rows, input int cols);
        return rows * cols;
    endfunction

    localparam int NUM_BLOCKS_C = calc_num_blocks(ROW_SIZE_MAT_C, COL_SIZE_MAT_C);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/matmul_out_serializer_fifo.sv
// Block-wide synchronous FIFO holding whole result blocks; occupancy is registered.
module out_block_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_wdata,
    output logic [W-1:0]               o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & (r_count != '0);
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/matmul_out_serializer.sv
// Buffers matmul result blocks and streams them out one slice per beat on an AXI-Stream-like port.
module matmul_out_serializer
    import linear_proj_pkg::*;
#(
    parameter int TOTAL_INPUT_W = 2,
    parameter int TOTAL_MODULES = 4,
    parameter int WIDTH_OUT     = 16,
    parameter int CHUNK_SIZE    = 4,
    parameter int NUM_CORES_A   = 2,
    parameter int NUM_CORES_B   = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int NUM_BLOCKS    = NUM_BLOCKS_C,
    localparam int SLICE_W      = calc_slice_w(WIDTH_OUT, CHUNK_SIZE, NUM_CORES_A,
                                               NUM_CORES_B, TOTAL_MODULES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [SLICE_W-1:0] in_data [TOTAL_INPUT_W],
    output logic [SLICE_W-1:0] m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tlast,
    output logic               overflow,
    output logic               busy,
    output logic               frame_done
);
    localparam int SIW = (TOTAL_INPUT_W > 1) ? $clog2(TOTAL_INPUT_W) : 1;
    localparam int BCW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int EW  = TOTAL_INPUT_W * SLICE_W;

    ser_state_e         r_state;
    ser_state_e         w_state_nxt;
    logic [SIW-1:0]     r_slice_idx;
    logic [BCW-1:0]     r_blk_cnt;
    logic               r_overflow;
    logic               r_frame_done;
    logic [EW-1:0]      w_wdata;
    logic [EW-1:0]      w_rdata;
    logic [CW-1:0]      w_count;
    logic               w_full;
    logic               w_push;
    logic               w_hs;
    logic               w_last_slice;
    logic               w_pop;
    logic [SLICE_W-1:0] w_head_slice;

    always_comb begin
        w_wdata = '0;
        for (int i = 0; i < TOTAL_INPUT_W; i++) w_wdata[i*SLICE_W +: SLICE_W] = in_data[i];
    end

    out_block_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_full  (w_full)
    );

    always_comb begin
        w_head_slice = '0;
        for (int i = 0; i < TOTAL_INPUT_W; i++)
            if (r_slice_idx == SIW'(i)) w_head_slice = w_rdata[i*SLICE_W +: SLICE_W];
    end

    // SEND tracks FIFO non-empty exactly, so a block pushed this cycle is offered next cycle.
    assign w_push       = in_valid & ~w_full;
    assign m_tvalid     = (r_state == SEND);
    assign w_hs         = m_tvalid & m_tready;
    assign w_last_slice = (r_slice_idx == SIW'(TOTAL_INPUT_W - 1));
    assign w_pop        = w_hs & w_last_slice;
    assign m_tdata      = m_tvalid ? w_head_slice : '0;
    assign m_tlast      = m_tvalid & w_last_slice & (r_blk_cnt == BCW'(NUM_BLOCKS - 1));
    assign overflow     = r_overflow;
    assign busy         = (w_count != '0);
    assign frame_done   = r_frame_done;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_push) w_state_nxt = SEND;
            SEND:    if (w_pop && !w_push && w_count == CW'(1)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_slice_idx  <= '0;
            r_blk_cnt    <= '0;
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_hs & m_tlast;
            if (in_valid && w_full) r_overflow <= 1'b1;
            if (w_hs) begin
                if (w_last_slice) begin
                    r_slice_idx <= '0;
                    r_blk_cnt   <= (r_blk_cnt == BCW'(NUM_BLOCKS - 1)) ? '0 : r_blk_cnt + BCW'(1);
                end else begin
                    r_slice_idx <= r_slice_idx + SIW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_matmul_out_serializer.sv
// Directed and randomized bench for matmul_out_serializer against a queue-based block model.
module tb_matmul_out_serializer;
    import linear_proj_pkg::*;

    localparam int TIW   = 2;
    localparam int DEPTH = 4;
    localparam int NB    = 8;
    localparam int SW    = calc_slice_w(16, 4, 2, 2, 4);

    typedef logic [TIW-1:0][SW-1:0] blk_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [SW-1:0] in_data [TIW];
    logic [SW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic          overflow;
    logic          busy;
    logic          frame_done;

    int n_err = 0;
    int n_chk = 0;
    int hs_cnt = 0;
    int tlast_at = 0;
    int tlast_n = 0;

    // Reference model: list of whole blocks plus output position.
    blk_t mq[$];
    int   msidx = 0;
    int   mblk = 0;
    bit   movf = 1'b0;
    bit   mfd = 1'b0;
    int   macc = 0;
    blk_t cur_blk;

    always #5 clk = ~clk;

    matmul_out_serializer #(
        .TOTAL_INPUT_W (TIW),
        .TOTAL_MODULES (4),
        .WIDTH_OUT     (16),
        .CHUNK_SIZE    (4),
        .NUM_CORES_A   (2),
        .NUM_CORES_B   (2),
        .FIFO_DEPTH    (DEPTH),
        .NUM_BLOCKS    (NB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .overflow   (overflow),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed(lo64)=%h expected(lo64)=%h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < TIW; i++)
            for (int w = 0; w < SW / 32; w++) b[i][w*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic drive_block(input blk_t b);
        for (int i = 0; i < TIW; i++) in_data[i] = b[i];
    endtask

    // One clock: check outputs at negedge against the model, advance the model, step past posedge.
    task automatic cycle();
        bit ev;
        bit hs;
        bit acc;
        @(negedge clk);
        ev = (mq.size() != 0);
        chk_bit("tvalid", m_tvalid, ev);
        if (ev) chk_data("tdata", m_tdata, mq[0][msidx]);
        chk_bit("tlast", m_tlast, ev && msidx == TIW - 1 && mblk == NB - 1);
        chk_bit("busy", busy, ev);
        chk_bit("overflow", overflow, movf);
        chk_bit("frame_done", frame_done, mfd);
        if (m_tvalid && m_tready) begin
            hs_cnt++;
            if (m_tlast) begin
                tlast_at = hs_cnt;
                tlast_n++;
            end
        end
        if (!rst_n) begin
            mq.delete();
            msidx = 0;
            mblk  = 0;
            movf  = 1'b0;
            mfd   = 1'b0;
        end else begin
            hs  = ev && m_tready;
            acc = in_valid && (mq.size() < DEPTH);
            mfd = hs && msidx == TIW - 1 && mblk == NB - 1;
            if (in_valid && !acc) movf = 1'b1;
            if (hs) begin
                if (msidx == TIW - 1) begin
                    void'(mq.pop_front());
                    msidx = 0;
                    mblk  = (mblk + 1) % NB;
                end else begin
                    msidx++;
                end
            end
            if (acc) begin
                for (int i = 0; i < TIW; i++) cur_blk[i] = in_data[i];
                mq.push_back(cur_blk);
                macc++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cycle();
        rst_n = 1'b1;
        hs_cnt   = 0;
        tlast_at = 0;
        tlast_n  = 0;
        macc     = 0;
    endtask

    initial begin
        blk_t b;
        bit   reached;
        for (int i = 0; i < TIW; i++) in_data[i] = '0;

        // Power-up reset
        @(posedge clk);
        #1;
        do_reset();
        chk_bit("rst_tvalid", m_tvalid, 1'b0);
        chk_data("rst_tdata", m_tdata, '0);
        chk_bit("rst_tlast", m_tlast, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_ovf", overflow, 1'b0);
        chk_bit("rst_fd", frame_done, 1'b0);

        // Single block {0xA, 0xB}
        m_tready = 1'b1;
        b = '0;
        b[0] = SW'(32'hA);
        b[1] = SW'(32'hB);
        drive_block(b);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk_data("single_s0", m_tdata, SW'(32'hA));
        cycle();
        chk_data("single_s1", m_tdata, SW'(32'hB));
        chk_bit("single_tlast", m_tlast, 1'b0);
        cycle();
        chk_bit("single_busy_low", busy, 1'b0);
        cycle();

        // Full frame: 8 blocks every 4 cycles
        do_reset();
        for (int k = 0; k < NB; k++) begin
            drive_block(rand_blk());
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            repeat (3) cycle();
        end
        repeat (4) cycle();
        chk_int("frame_slices", hs_cnt, NB * TIW);
        chk_int("frame_tlast_pos", tlast_at, NB * TIW);
        chk_int("frame_tlast_n", tlast_n, 1);
        chk_bit("frame_ovf", overflow, 1'b0);

        // Stalled output: 5 pulses, 5th dropped
        do_reset();
        m_tready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c % 4 == 0);
            if (in_valid) drive_block(rand_blk());
            cycle();
        end
        in_valid = 1'b0;
        chk_bit("stall_ovf", overflow, 1'b1);
        m_tready = 1'b1;
        repeat (12) cycle();
        chk_int("stall_slices", hs_cnt, 8);
        chk_bit("stall_ovf_sticky", overflow, 1'b1);

        // Ready toggling every cycle, random arrivals
        do_reset();
        for (int c = 0; c < 120; c++) begin
            m_tready = (c % 2 == 0);
            in_valid = ($urandom_range(0, 3) == 0);
            if (in_valid) drive_block(rand_blk());
            cycle();
        end
        in_valid = 1'b0;
        m_tready = 1'b1;
        repeat (2 * DEPTH * TIW + 2) cycle();
        chk_int("toggle_slices", hs_cnt, macc * TIW);

        // Push coinciding with last-slice pop: full -> dropped, not full -> accepted
        do_reset();
        m_tready = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            drive_block(rand_blk());
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        m_tready = 1'b1;
        cycle();
        drive_block(rand_blk());
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk_bit("popfull_ovf", overflow, 1'b1);
        cycle();
        drive_block(rand_blk());
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (12) cycle();
        chk_int("popfull_slices", hs_cnt, (DEPTH + 1) * TIW);

        // Reset while slice 1 of block 3 is pending, then a clean frame
        do_reset();
        m_tready = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 200 && !reached; c++) begin
            in_valid = (c % 3 == 0);
            if (in_valid) drive_block(rand_blk());
            cycle();
            reached = (mq.size() != 0 && mblk == 3 && msidx == 1);
        end
        chk_bit("reach_b3s1", reached, 1'b1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk_bit("midrst_tvalid", m_tvalid, 1'b0);
        chk_bit("midrst_busy", busy, 1'b0);
        hs_cnt   = 0;
        tlast_at = 0;
        tlast_n  = 0;
        cycle();
        for (int k = 0; k < NB; k++) begin
            drive_block(rand_blk());
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            repeat (2) cycle();
        end
        repeat (6) cycle();
        chk_int("midrst_tlast_pos", tlast_at, NB * TIW);
        chk_int("midrst_slices", hs_cnt, NB * TIW);

        // Random traffic and backpressure
        do_reset();
        for (int c = 0; c < 400; c++) begin
            m_tready = ($urandom_range(0, 2) != 0);
            in_valid = ($urandom_range(0, 2) == 0);
            if (in_valid) drive_block(rand_blk());
            cycle();
        end
        in_valid = 1'b0;
        m_tready = 1'b1;
        repeat (2 * DEPTH * TIW + 2) cycle();
        chk_int("rand_slices", hs_cnt, macc * TIW);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/matmul_out_serializer.md
MATMUL_OUT_SERIALIZER -- requirements
Module: matmul_out_serializer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  TOTAL_INPUT_W, 2, output slices per result block
  TOTAL_MODULES, 4, matmul modules per slice
  WIDTH_OUT, 16, output element width
  CHUNK_SIZE, 4, elements per chunk
  NUM_CORES_A, 2, A-side cores
  NUM_CORES_B, 2, B-side cores
  FIFO_DEPTH, 4, buffered result blocks (power of 2, >=2)
  NUM_BLOCKS, 8, result blocks per matrix C (ROW_SIZE_MAT_C*COL_SIZE_MAT_C)
REQ-002 SLICE_W SHALL equal WIDTH_OUT*CHUNK_SIZE*NUM_CORES_A*NUM_CORES_B*TOTAL_MODULES.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  clock
  rst_n  in  1  reset: synchronous, active-low; clock clk
  in_valid  in  1  one-cycle pulse, result block present (matmul wrapper out_valid)
  in_data  in  SLICE_W x TOTAL_INPUT_W (unpacked array)  result block
  m_tdata  out  SLICE_W  serialized slice
  m_tvalid  out  1  slice valid
  m_tready  in  1  downstream ready
  m_tlast  out  1  last slice of last block of matrix C
  overflow  out  1  sticky: block dropped
  busy  out  1  FIFO non-empty or slice pending
  frame_done  out  1  one-cycle pulse after final m_tlast handshake

Function
REQ-004 On in_valid=1 with FIFO occupancy < FIFO_DEPTH (registered value, start of cycle), all TOTAL_INPUT_W slices SHALL be written as one entry; no same-cycle pass-through.
REQ-005 On in_valid=1 with FIFO full, the block SHALL be dropped, overflow set to 1 and held until reset; the block counter SHALL NOT advance.
REQ-006 Earliest m_tvalid SHALL be the cycle after the accepting in_valid (1-cycle latency).
REQ-007 FSM states SHALL be IDLE, SEND; IDLE->SEND when FIFO non-empty; SEND->IDLE when the last slice of the head entry handshakes and FIFO becomes empty; SEND stays SEND otherwise.
REQ-008 In SEND, m_tdata SHALL be head entry slice slice_idx, slice 0 first, ascending to TOTAL_INPUT_W-1.
REQ-009 A handshake (m_tvalid & m_tready) SHALL advance slice_idx; on slice TOTAL_INPUT_W-1 slice_idx wraps to 0, the entry pops, and the block counter increments.
REQ-010 While m_tvalid=1 and m_tready=0, m_tdata and m_tlast SHALL remain stable.
REQ-011 m_tlast SHALL be 1 only on slice TOTAL_INPUT_W-1 of block index NUM_BLOCKS-1 (counting from 0).
REQ-012 After the m_tlast handshake, the output block counter SHALL wrap to 0 and frame_done SHALL pulse the next cycle.
REQ-013 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-014 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-015 busy SHALL equal (occupancy != 0).

Reset
REQ-016 rst_n=0 at a clock edge SHALL clear pointers, occupancy, slice_idx, block counter, state=IDLE, m_tvalid=0, m_tlast=0, overflow=0, frame_done=0, busy=0; m_tdata reset value 0.
REQ-017 Reset mid-transfer SHALL discard all buffered blocks; no slice is emitted in the first cycle after reset release.
REQ-018 FIFO storage array SHALL NOT require reset.

Structure
REQ-019 SLICE_W derivation, NUM_BLOCKS computation and the state enum SHALL live in linear_proj_pkg.
REQ-020 Storage SHALL be one sub-module, out_block_fifo (synchronous, FIFO_DEPTH x TOTAL_INPUT_W*SLICE_W, registered occupancy); the FSM/serializer SHALL stay in the top.

Verification
REQ-021 Single block, m_tready=1, in_data={0xA,0xB}: m_tdata 0xA at T+1, 0xB at T+2, m_tlast=0, busy low at T+3.
REQ-022 Eight blocks back-to-back every 4 cycles, m_tready=1: 16 slices in order, m_tlast only on 16th, frame_done pulse one cycle later, overflow=0.
REQ-023 m_tready=0 for 20 cycles, 5 in_valid pulses: first 4 buffered, 5th dropped, overflow=1 sticky; on m_tready=1, 8 slices emitted in order.
REQ-024 m_tready toggling 1/0 each cycle: m_tdata/m_tlast stable during stalls, no slice lost or duplicated (scoreboard).
REQ-025 Push on the cycle head entry's last slice pops with FIFO full: push accepted only if occupancy<FIFO_DEPTH at cycle start, else dropped, overflow=1.
REQ-026 rst_n=0 asserted while slice 1 of block 3 pending: next cycle m_tvalid=0, busy=0, block counter 0; following 8-block frame produces m_tlast on its 16th slice.
